id_rename_issue: RTL and testbench

//  Parametrised decode-to-issue stage for the Tomasulo core: accepts one decoded uop per cycle (valid/ready),

---
 rtl/id_rename_issue.sv | 219 +++++++++++++++++++++
 tb/tb_id_rename_issue.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_rename_issue.sv
// ---------------------------------------------------------------------------
// id_rename_issue
//
// Decode-to-issue stage of the Tomasulo core. Takes one decoded uop per cycle
// over a valid/ready handshake, renames its sources through a per-register
// ROB tag table, and allocates a ROB entry. The renamed operands go into a
// single issue register facing the reservation stations of EX_UNITS units.
// A uop whose target unit is out of range is consumed and only counted.
//
// A tag of 0 means "value is in the table". Register 0 always reads as
// (tag 0, value 0).
//
// Build option:
//   ID_CM_BYPASS_EN  defined   : a source whose tag matches this cycle's
//                                commit reads (tag 0, cm_val) directly.
//                    undefined : such a source stalls in_ready for one cycle.
//                                By the next cycle the commit has cleared the tag.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   flush             mispredict flush: clear all tags, drop the issue register
//   in_valid/in_ready decoded uop handshake (fire = in_valid & in_ready)
//   in_op, in_ex_unit op type and target unit (>= EX_UNITS marks an error uop)
//   in_rs1/2, in_rs_en source registers and their use flags
//   in_imm, in_imm_en immediate and "src2 is the immediate"
//   in_rd, in_rd_en   destination register and write flag
//   rob_full, rob_tag ROB back-pressure and next free (nonzero) tag
//   rob_alloc         ROB allocate strobe (combinational)
//   rob_rd, rob_op    destination (0 when unused) and op for the new ROB entry
//   cm_valid/rd/tag/val  ROB commit
//   rs_full           per-unit reservation station full
//   out_*             issue register: valid, unit, op, tags, values, ROB tag
//   err_cnt           saturating count of dropped error uops
// ---------------------------------------------------------------------------
module id_rename_issue #(
    parameter int XLEN     = 32,
    parameter int REG_NUM  = 32,
    parameter int TAG_W    = 4,
    parameter int EX_UNITS = 4,
    parameter int OP_W     = 6,
    localparam int RW      = $clog2(REG_NUM),
    localparam int UW      = $clog2(EX_UNITS) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     in_op,
    input  logic [UW-1:0]       in_ex_unit,
    input  logic [RW-1:0]       in_rs1,
    input  logic [RW-1:0]       in_rs2,
    input  logic [1:0]          in_rs_en,
    input  logic [XLEN-1:0]     in_imm,
    input  logic                in_imm_en,
    input  logic [RW-1:0]       in_rd,
    input  logic                in_rd_en,

    input  logic                rob_full,
    input  logic [TAG_W-1:0]    rob_tag,
    output logic                rob_alloc,
    output logic [RW-1:0]       rob_rd,
    output logic [OP_W-1:0]     rob_op,

    input  logic                cm_valid,
    input  logic [RW-1:0]       cm_rd,
    input  logic [TAG_W-1:0]    cm_tag,
    input  logic [XLEN-1:0]     cm_val,

    input  logic [EX_UNITS-1:0] rs_full,
    output logic                out_valid,
    output logic [UW-1:0]       out_ex_unit,
    output logic [OP_W-1:0]     out_op,
    output logic [TAG_W-1:0]    out_tag1,
    output logic [TAG_W-1:0]    out_tag2,
    output logic [XLEN-1:0]     out_val1,
    output logic [XLEN-1:0]     out_val2,
    output logic [TAG_W-1:0]    out_target,
    output logic [15:0]         err_cnt
);

    // Rename table: producer tag and last committed value per register.
    logic [TAG_W-1:0] tag_q [REG_NUM];
    logic [XLEN-1:0]  val_q [REG_NUM];

    logic             out_blocked;
    logic             accept;
    logic             is_err;
    logic             hazard;
    logic             fire;
    logic             ren_en;
    logic             hit1;
    logic             hit2;
    logic [TAG_W-1:0] raw_tag1;
    logic [TAG_W-1:0] raw_tag2;
    logic [XLEN-1:0]  raw_val1;
    logic [XLEN-1:0]  raw_val2;
    logic [TAG_W-1:0] src_tag1;
    logic [TAG_W-1:0] src_tag2;
    logic [XLEN-1:0]  src_val1;
    logic [XLEN-1:0]  src_val2;

    // Only legal units are ever loaded into the issue register, so a unit
    // index past the rs_full vector simply never blocks.
    always_comb begin
        out_blocked = 1'b0;
        for (int u = 0; u < EX_UNITS; u++) begin
            if (out_ex_unit == UW'(u)) begin
                out_blocked = rs_full[u];
            end
        end
    end

    assign accept = out_valid & ~out_blocked;
    assign is_err = (in_ex_unit >= UW'(EX_UNITS));

    // Operand read from the table as it stands before this cycle's updates,
    // so a uop with rs == rd sees the previous producer's tag.
    always_comb begin
        raw_tag1 = (in_rs_en[0] && (in_rs1 != '0)) ? tag_q[in_rs1] : '0;
        raw_val1 = (in_rs1 != '0) ? val_q[in_rs1] : '0;
        raw_tag2 = '0;
        raw_val2 = in_imm;
        if (!in_imm_en) begin
            raw_tag2 = (in_rs_en[1] && (in_rs2 != '0)) ? tag_q[in_rs2] : '0;
            raw_val2 = (in_rs2 != '0) ? val_q[in_rs2] : '0;
        end

        // A source still waiting on the tag being committed right now.
        hit1 = cm_valid && (raw_tag1 != '0) && (raw_tag1 == cm_tag);
        hit2 = cm_valid && (raw_tag2 != '0) && (raw_tag2 == cm_tag);

`ifdef ID_CM_BYPASS_EN
        hazard   = 1'b0;
        src_tag1 = hit1 ? '0 : raw_tag1;
        src_val1 = hit1 ? cm_val : raw_val1;
        src_tag2 = hit2 ? '0 : raw_tag2;
        src_val2 = hit2 ? cm_val : raw_val2;
`else
        hazard   = hit1 | hit2;
        src_tag1 = raw_tag1;
        src_val1 = raw_val1;
        src_tag2 = raw_tag2;
        src_val2 = raw_val2;
`endif
    end

    assign in_ready  = rst & ~flush & ~rob_full & (~out_valid | accept) & ~hazard;
    assign fire      = in_valid & in_ready;
    assign rob_alloc = fire & ~is_err;
    assign rob_rd    = in_rd_en ? in_rd : '0;
    assign rob_op    = in_op;
    assign ren_en    = rob_alloc & in_rd_en & (in_rd != '0);

    // Rename table update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                tag_q[r] <= '0;
                val_q[r] <= '0;
            end
        end else begin
            // A commit always delivers its value, even during a flush.
            if (cm_valid && (cm_rd != '0)) begin
                val_q[cm_rd] <= cm_val;
            end
            if (flush) begin
                for (int r = 0; r < REG_NUM; r++) begin
                    tag_q[r] <= '0;
                end
            end else begin
                // Clear only if the committing ROB entry is still the newest
                // producer; a same-cycle rename of that register takes priority.
                if (cm_valid && (cm_rd != '0) && (tag_q[cm_rd] == cm_tag) &&
                    !(ren_en && (in_rd == cm_rd))) begin
                    tag_q[cm_rd] <= '0;
                end
                if (ren_en) begin
                    tag_q[in_rd] <= rob_tag;
                end
            end
        end
    end

    // Issue register. Error uops never load it; they behave as a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_ex_unit <= '0;
            out_op      <= '0;
            out_tag1    <= '0;
            out_tag2    <= '0;
            out_val1    <= '0;
            out_val2    <= '0;
            out_target  <= '0;
        end else if (rob_alloc) begin
            out_valid   <= 1'b1;
            out_ex_unit <= in_ex_unit;
            out_op      <= in_op;
            out_tag1    <= src_tag1;
            out_tag2    <= src_tag2;
            out_val1    <= src_val1;
            out_val2    <= src_val2;
            out_target  <= rob_tag;
        end else if (flush || accept) begin
            out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (fire && is_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_rename_issue.sv
module tb_id_rename_issue;
    localparam int XLEN = 32;
    localparam int REG_NUM = 32;
    localparam int TAG_W = 4;
    localparam int EX_UNITS = 4;
    localparam int OP_W = 6;
    localparam int RW = 5;
    localparam int UW = 3;

    logic                clk = 1'b0;
    logic                rst, flush, in_valid, in_ready;
    logic [OP_W-1:0]     in_op;
    logic [UW-1:0]       in_ex_unit;
    logic [RW-1:0]       in_rs1, in_rs2, in_rd;
    logic [1:0]          in_rs_en;
    logic [XLEN-1:0]     in_imm;
    logic                in_imm_en, in_rd_en, rob_full;
    logic [TAG_W-1:0]    rob_tag;
    logic                rob_alloc;
    logic [RW-1:0]       rob_rd;
    logic [OP_W-1:0]     rob_op;
    logic                cm_valid;
    logic [RW-1:0]       cm_rd;
    logic [TAG_W-1:0]    cm_tag;
    logic [XLEN-1:0]     cm_val;
    logic [EX_UNITS-1:0] rs_full;
    logic                out_valid;
    logic [UW-1:0]       out_ex_unit;
    logic [OP_W-1:0]     out_op;
    logic [TAG_W-1:0]    out_tag1, out_tag2, out_target;
    logic [XLEN-1:0]     out_val1, out_val2;
    logic [15:0]         err_cnt;

    always #5 clk = ~clk;

    id_rename_issue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_ex_unit(in_ex_unit),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs_en(in_rs_en), .in_imm(in_imm),
        .in_imm_en(in_imm_en), .in_rd(in_rd), .in_rd_en(in_rd_en),
        .rob_full(rob_full), .rob_tag(rob_tag), .rob_alloc(rob_alloc),
        .rob_rd(rob_rd), .rob_op(rob_op),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_val(cm_val),
        .rs_full(rs_full), .out_valid(out_valid), .out_ex_unit(out_ex_unit), .out_op(out_op),
        .out_tag1(out_tag1), .out_tag2(out_tag2), .out_val1(out_val1), .out_val2(out_val2),
        .out_target(out_target), .err_cnt(err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural view of the rename table and issue slot.
    logic [TAG_W-1:0] m_tag [REG_NUM];
    logic [XLEN-1:0]  m_val [REG_NUM];
    logic             m_ov;
    logic [UW-1:0]    m_unit;
    logic [OP_W-1:0]  m_op;
    logic [TAG_W-1:0] m_t1, m_t2, m_tgt;
    logic [XLEN-1:0]  m_v1, m_v2;
    int               m_err;

    task automatic model_clear();
        for (int r = 0; r < REG_NUM; r++) begin
            m_tag[r] = '0;
            m_val[r] = '0;
        end
        m_ov = 1'b0; m_unit = '0; m_op = '0; m_t1 = '0; m_t2 = '0;
        m_tgt = '0; m_v1 = '0; m_v2 = '0; m_err = 0;
    endtask

    function automatic logic [TAG_W-1:0] src_tag(input logic [RW-1:0] r, input logic en);
        return (en && (r != '0)) ? m_tag[r] : '0;
    endfunction

    // One clock: check combinational outputs, advance model, check registers.
    task automatic step();
        logic [TAG_W-1:0] t1, t2;
        logic [XLEN-1:0]  v1, v2;
        logic             h1, h2, acc, stall, rdy, fire, bad;
        t1 = src_tag(in_rs1, in_rs_en[0]);
        v1 = (in_rs1 == '0) ? '0 : m_val[in_rs1];
        if (in_imm_en) begin
            t2 = '0;
            v2 = in_imm;
        end else begin
            t2 = src_tag(in_rs2, in_rs_en[1]);
            v2 = (in_rs2 == '0) ? '0 : m_val[in_rs2];
        end
        h1 = cm_valid && (t1 != '0) && (t1 == cm_tag);
        h2 = cm_valid && (t2 != '0) && (t2 == cm_tag);
`ifdef ID_CM_BYPASS_EN
        stall = 1'b0;
        if (h1) begin t1 = '0; v1 = cm_val; end
        if (h2) begin t2 = '0; v2 = cm_val; end
`else
        stall = h1 || h2;
`endif
        acc  = m_ov && !rs_full[m_unit];
        rdy  = rst && !flush && !rob_full && (!m_ov || acc) && !stall;
        bad  = (int'(in_ex_unit) >= EX_UNITS);
        fire = in_valid && rdy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("rob_alloc", 32'(rob_alloc), 32'(fire && !bad));
        chk("rob_rd", 32'(rob_rd), in_rd_en ? 32'(in_rd) : 32'd0);
        chk("rob_op", 32'(rob_op), 32'(in_op));
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            if (cm_valid && cm_rd != '0) m_val[cm_rd] = cm_val;
            if (flush) begin
                for (int r = 0; r < REG_NUM; r++) m_tag[r] = '0;
            end else begin
                if (cm_valid && cm_rd != '0 && m_tag[cm_rd] == cm_tag) m_tag[cm_rd] = '0;
                if (fire && !bad && in_rd_en && in_rd != '0) m_tag[in_rd] = rob_tag;
            end
            if (fire && !bad) begin
                m_ov = 1'b1; m_unit = in_ex_unit; m_op = in_op;
                m_t1 = t1; m_t2 = t2; m_v1 = v1; m_v2 = v2; m_tgt = rob_tag;
            end else if (flush || acc) begin
                m_ov = 1'b0;
            end
            if (fire && bad && m_err < 65535) m_err++;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
        if (m_ov) begin
            chk("out_ex_unit", 32'(out_ex_unit), 32'(m_unit));
            chk("out_op", 32'(out_op), 32'(m_op));
            chk("out_tag1", 32'(out_tag1), 32'(m_t1));
            chk("out_tag2", 32'(out_tag2), 32'(m_t2));
            chk("out_val1", out_val1, m_v1);
            chk("out_val2", out_val2, m_v2);
            chk("out_target", 32'(out_target), 32'(m_tgt));
        end
    endtask

    task automatic idle();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_ex_unit = '0;
        in_rs1 = '0; in_rs2 = '0; in_rs_en = '0; in_imm = '0; in_imm_en = 1'b0;
        in_rd = '0; in_rd_en = 1'b0; rob_full = 1'b0; rob_tag = 4'd1;
        cm_valid = 1'b0; cm_rd = '0; cm_tag = '0; cm_val = '0; rs_full = '0;
    endtask

    task automatic uop(input int unit, input int rd, input int rs1, input int rs2,
                       input logic [1:0] en, input logic imm_en, input logic [31:0] imm,
                       input int tag);
        in_valid = 1'b1; in_op = OP_W'(tag + 3); in_ex_unit = UW'(unit);
        in_rd = RW'(rd); in_rd_en = (rd != 0); in_rs1 = RW'(rs1); in_rs2 = RW'(rs2);
        in_rs_en = en; in_imm_en = imm_en; in_imm = imm; rob_tag = TAG_W'(tag);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        idle();
    endtask

    typedef struct {
        logic [UW-1:0]       unit;
        logic [RW-1:0]       rd, rs1, rs2;
        logic [1:0]          rs_en;
        logic                imm_en;
        logic [XLEN-1:0]     imm;
        logic [TAG_W-1:0]    tag;
        logic                rob_full;
        logic [EX_UNITS-1:0] rs_full;
        logic                e_ready, e_ov;
        logic [TAG_W-1:0]    e_t1, e_t2;
        logic [XLEN-1:0]     e_v2;
        logic [15:0]         e_err;
    } vec_t;

    vec_t vt [8];

    initial begin
        // unit rd rs1 rs2 en imm_en imm tag rob_full rs_full | ready ov t1 t2 v2 err
        vt[0] = '{3'd0, 5'd3,  5'd1, 5'd2, 2'b11, 1'b0, 32'd0, 4'd5,  1'b0, 4'b0000, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 16'd0};
        vt[1] = '{3'd0, 5'd4,  5'd3, 5'd0, 2'b01, 1'b1, 32'd7, 4'd6,  1'b0, 4'b0000, 1'b1, 1'b1, 4'd5, 4'd0, 32'd7, 16'd0};
        vt[2] = '{3'd1, 5'd5,  5'd4, 5'd3, 2'b11, 1'b0, 32'd0, 4'd7,  1'b0, 4'b0000, 1'b1, 1'b1, 4'd6, 4'd5, 32'd0, 16'd0};
        vt[3] = '{3'd4, 5'd1,  5'd0, 5'd0, 2'b00, 1'b0, 32'd0, 4'd8,  1'b0, 4'b0000, 1'b1, 1'b0, 4'd0, 4'd0, 32'd0, 16'd1};
        vt[4] = '{3'd2, 5'd7,  5'd1, 5'd0, 2'b01, 1'b0, 32'd0, 4'd9,  1'b0, 4'b0000, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 16'd1};
        vt[5] = '{3'd0, 5'd8,  5'd7, 5'd0, 2'b01, 1'b0, 32'd0, 4'd10, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 16'd1};
        vt[6] = '{3'd3, 5'd9,  5'd7, 5'd0, 2'b01, 1'b0, 32'd0, 4'd11, 1'b0, 4'b1111, 1'b1, 1'b1, 4'd9, 4'd0, 32'd0, 16'd1};
        vt[7] = '{3'd0, 5'd10, 5'd9, 5'd0, 2'b01, 1'b0, 32'd0, 4'd12, 1'b0, 4'b1111, 1'b0, 1'b1, 4'd9, 4'd0, 32'd0, 16'd1};

        model_clear();
        idle();

        // Reset held two cycles with an error uop offered: nothing may count.
        rst = 1'b0; in_valid = 1'b1; in_ex_unit = 3'd4;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_err_cnt", 32'(err_cnt), 32'd0);
            chk("rst_out_tag1", 32'(out_tag1), 32'd0);
            chk("rst_out_target", 32'(out_target), 32'd0);
        end
        idle();
        #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            idle();
            uop(int'(vt[i].unit), int'(vt[i].rd), int'(vt[i].rs1), int'(vt[i].rs2),
                vt[i].rs_en, vt[i].imm_en, vt[i].imm, int'(vt[i].tag));
            rob_full = vt[i].rob_full;
            rs_full  = vt[i].rs_full;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vt[i].e_ready));
            step();
            chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(vt[i].e_ov));
            chk($sformatf("vec%0d_err", i), 32'(err_cnt), 32'(vt[i].e_err));
            if (vt[i].e_ov) begin
                chk($sformatf("vec%0d_tag1", i), 32'(out_tag1), 32'(vt[i].e_t1));
                chk($sformatf("vec%0d_tag2", i), 32'(out_tag2), 32'(vt[i].e_t2));
                chk($sformatf("vec%0d_val2", i), out_val2, vt[i].e_v2);
            end
        end

        // Commit landing on a source in the same cycle.
        do_reset();
        uop(0, 3, 0, 0, 2'b00, 1'b0, 32'd0, 5);
        step();
        idle();
        uop(0, 4, 3, 0, 2'b01, 1'b0, 32'd0, 6);
        cm_valid = 1'b1; cm_rd = 5'd3; cm_tag = 4'd5; cm_val = 32'h55;
`ifdef ID_CM_BYPASS_EN
        #1;
        chk("byp_ready", 32'(in_ready), 32'd1);
        step();
`else
        #1;
        chk("haz_ready", 32'(in_ready), 32'd0);
        step();
        cm_valid = 1'b0;
        #1;
        chk("haz_retry_ready", 32'(in_ready), 32'd1);
        step();
`endif
        chk("cm_src_ov", 32'(out_valid), 32'd1);
        chk("cm_src_tag1", 32'(out_tag1), 32'd0);
        chk("cm_src_val1", out_val1, 32'h55);

        // Reservation-station back-pressure holds the issue register.
        do_reset();
        uop(2, 1, 0, 0, 2'b00, 1'b0, 32'd0, 3);
        step();
        uop(0, 2, 0, 0, 2'b00, 1'b0, 32'd0, 4);
        rs_full = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", 32'(in_ready), 32'd0);
            step();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_target", 32'(out_target), 32'd3);
        end
        rs_full = 4'b0000;
        step();
        chk("release_valid", 32'(out_valid), 32'd1);
        chk("release_target", 32'(out_target), 32'd4);

        // Stale commit, flush, and rename-beats-commit.
        do_reset();
        uop(0, 7, 0, 0, 2'b00, 1'b0, 32'd0, 9);
        step();
        idle();
        cm_valid = 1'b1; cm_rd = 5'd7; cm_tag = 4'd2; cm_val = 32'hABCD;
        step();
        idle();
        uop(0, 0, 7, 0, 2'b01, 1'b0, 32'd0, 3);
        step();
        chk("stale_cm_tag", 32'(out_tag1), 32'd9);
        chk("stale_cm_val", out_val1, 32'hABCD);
        idle();
        uop(0, 0, 7, 0, 2'b01, 1'b0, 32'd0, 5);
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(in_ready), 32'd0);
        step();
        chk("flush_ov", 32'(out_valid), 32'd0);
        idle();
        uop(0, 0, 7, 0, 2'b01, 1'b0, 32'd0, 5);
        step();
        chk("post_flush_tag", 32'(out_tag1), 32'd0);
        chk("post_flush_val", out_val1, 32'hABCD);
        idle();
        uop(0, 7, 0, 0, 2'b00, 1'b0, 32'd0, 9);
        step();
        idle();
        uop(0, 7, 0, 0, 2'b00, 1'b0, 32'd0, 4);
        cm_valid = 1'b1; cm_rd = 5'd7; cm_tag = 4'd9; cm_val = 32'h77;
        step();
        idle();
        uop(0, 0, 7, 0, 2'b01, 1'b0, 32'd0, 6);
        step();
        chk("rename_wins_tag", 32'(out_tag1), 32'd4);
        chk("rename_wins_val", out_val1, 32'h77);

        // Randomised traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 299) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_op      = OP_W'($urandom);
            in_ex_unit = ($urandom_range(0, 9) == 0) ? UW'($urandom_range(4, 7)) : UW'($urandom_range(0, 3));
            in_rs1     = RW'($urandom_range(0, 7));
            in_rs2     = RW'($urandom_range(0, 7));
            in_rs_en   = 2'($urandom);
            in_imm     = $urandom;
            in_imm_en  = ($urandom_range(0, 3) == 0);
            in_rd      = RW'($urandom_range(0, 7));
            in_rd_en   = ($urandom_range(0, 3) != 0);
            rob_full   = ($urandom_range(0, 9) == 0);
            rob_tag    = TAG_W'($urandom_range(1, 15));
            cm_valid   = ($urandom_range(0, 1) == 1);
            cm_rd      = RW'($urandom_range(0, 7));
            cm_tag     = ($urandom_range(0, 2) != 0) ? m_tag[cm_rd] : TAG_W'($urandom_range(0, 15));
            cm_val     = $urandom;
            rs_full    = EX_UNITS'($urandom & $urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
